serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Brief    : Bit-serial adder (LSB first, one full adder, WIDTH+1 cycles per
//            operation). Define SERIAL_SUB_EN to add the sub port (a-b mode).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_unused_res;

  // Subtraction is a + ~b + 1, so only the loaded b value and carry change.
`ifdef SERIAL_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == c_last);

  assign w_s  = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_co = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

  // The oldest bit falls off the bottom of the result register on each shift.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_s;
    end else begin : g_res_wn
      assign w_res_next = {w_s, r_res[WIDTH-1:1]};
    end
  endgenerate
  assign w_unused_res = r_res[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = start ? S_RUN : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_res   <= w_res_next;
      r_carry <= w_co;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + CW'(1);
      // Publish together with the final bit so sum is valid while done is high.
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Brief    : Scoreboard bench for serial_add_ctrl with directed and random ops.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the operation timeline: acc is the edge that accepted the
  // current op, next_ok the first edge at which a new start is taken.
  int           acc     = -1000;
  int           next_ok = 0;
  bit           active  = 1'b0;
  bit           mon_en  = 1'b0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] hold_sum  = '0;
  logic         hold_cout = 1'b0;
  int           n_cmp  = 0;
  int           n_fail = 0;

  function automatic logic [W:0] ref_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                                        input logic c, input logic s);
    longint ai;
    longint bi;
    longint t;
    logic [W:0] r;
    ai = longint'(av);
    bi = longint'(bv);
    if (s) begin
      t = (ai - bi) & ((64'd1 << W) - 1);
      r = {(ai >= bi), t[W-1:0]};
    end else begin
      t = ai + bi + longint'(c);
      r = t[W:0];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic c, input logic s);
    int n;
    @(negedge clk);
    rst   = r;
    start = st;
    a     = av;
    b     = bv;
    cin   = c;
`ifdef SERIAL_SUB_EN
    sub   = s;
`endif
    n = cyc + 1;
    if (r) begin
      active  = 1'b0;
      next_ok = n + 1;
      mon_en  = 1'b1;
    end else if (st && n >= next_ok) begin
      exp_q.push_back(ref_op(av, bv, c, s));
      acc     = n;
      active  = 1'b1;
      next_ok = n + W + 1;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                    input logic s);
    drive(1'b0, 1'b1, av, bv, c, s);
    idle(W + 2);
  endtask

  // Monitor: samples 1 time unit after each edge, pops on every done pulse.
  always @(posedge clk) begin
    logic [W:0] e;
    bit         exp_busy;
    bit         exp_done;
    #1;
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        hold_sum  = '0;
        hold_cout = 1'b0;
      end
      exp_busy = active && (cyc >= acc) && (cyc < acc + W);
      exp_done = active && (cyc == acc + W);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL done_unexpected at cycle %0d: got done=1, expected no pending op", cyc);
        end else begin
          e = exp_q.pop_front();
          hold_sum  = e[W-1:0];
          hold_cout = e[W];
        end
      end
      chk("sum", 32'(sum), 32'(hold_sum));
      chk("cout", 32'(cout), 32'(hold_cout));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
    idle(2);

    op(8'h5A, 8'h33, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 1'b0);
    op(8'hFF, 8'hFF, 1'b1, 1'b0);

    // start re-asserted mid-run must be ignored
    drive(1'b0, 1'b1, 8'h5A, 8'h33, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    idle(W + 2);

    // reset mid-run aborts the op and clears the outputs
    drive(1'b0, 1'b1, 8'hC3, 8'h7E, 1'b1, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(W + 3);

    // start held high through RUN and DONE: back-to-back ops
    op(8'h12, 8'h34, 1'b0, 1'b0);
    for (int i = 0; i < 2 * W + 3; i++) drive(1'b0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    idle(W + 2);

`ifdef SERIAL_SUB_EN
    op(8'h10, 8'h01, 1'b0, 1'b1);
    op(8'h01, 8'h02, 1'b1, 1'b1);
    op(8'h80, 8'h80, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 300; i++) begin
      logic r;
      logic st;
      logic s;
      r  = ($urandom_range(0, 59) == 0);
      st = ($urandom_range(0, 2) != 0);
`ifdef SERIAL_SUB_EN
      s  = 1'($urandom_range(0, 1));
`else
      s  = 1'b0;
`endif
      drive(r, st, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s);
    end
    idle(W + 3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
